// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM states and request-decode helpers for the data-memory LSU.
package data_memory_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_e;

  // Illegal width code for the direction, or an access not aligned to its size.
  function automatic logic req_fault(input logic [2:0] f3, input logic is_store,
                                     input logic [1:0] addr_lo);
    logic bad_code;
    logic misaligned;
    case (f3)
      F3_B, F3_H, F3_W: bad_code = 1'b0;
      F3_BU, F3_HU:     bad_code = is_store;
      default:          bad_code = 1'b1;
    endcase
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && addr_lo[0]) ||
                 ((f3 == F3_W) && (addr_lo != 2'b00));
    return bad_code | misaligned;
  endfunction

  // Byte lanes touched by a store of the given width at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_B:    return 4'b0001 << addr_lo;
      F3_H:    return 4'b0011 << addr_lo;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Request/response handshake bundle between a load/store client and the LSU.
interface data_memory_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_aligner.sv
// Extracts the addressed byte/half/word from a memory word and sign/zero-extends it.
module load_aligner
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to the width code.
  always_comb begin
    byte_sel  = 8'(word_i >> {addr_lo_i, 3'b000});
    half_sel  = 16'(word_i >> {addr_lo_i[1], 4'b0000});
    rdata_c_o = '0;
    case (funct3_i)
      F3_B:    rdata_c_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_c_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata_c_o = word_i;
      F3_BU:   rdata_c_o = {24'd0, byte_sel};
      F3_HU:   rdata_c_o = {16'd0, half_sel};
      default: rdata_c_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Single-port word memory with byte-granular stores, aligned loads, error
// detection and an optional post-reset zeroing sweep.
module data_memory_lsu
  import data_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  data_memory_lsu_if.slave bus,
  output logic             busy_clear
);

  // ADDR_WIDTH must cover at least the byte span of the array.
  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam int unsigned BYTE_AW = IDX_W + 2;

  lsu_state_e       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;
  logic             busy_clear_q, busy_clear_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             accept;
  logic             out_of_range;
  logic             req_err;
  logic [IDX_W-1:0] widx;
  logic [1:0]       addr_lo;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic             mem_clr;
  logic             mem_we;

  assign widx    = bus.req_addr[BYTE_AW-1:2];
  assign addr_lo = bus.req_addr[1:0];

  // Any address bit above the array span set means the access is out of range.
  generate
    if (ADDR_WIDTH > BYTE_AW) begin : g_range
      assign out_of_range = |bus.req_addr[ADDR_WIDTH-1:BYTE_AW];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign req_err = out_of_range | req_fault(bus.req_funct3, bus.req_write, addr_lo);

  assign bus.req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.resp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  assign wr_be   = store_be(bus.req_funct3, addr_lo);
  assign wr_data = bus.req_wdata << {addr_lo, 3'b000};
  assign rd_word = mem_q[widx];

  load_aligner u_load_aligner (
    .word_i    (rd_word),
    .addr_lo_i (addr_lo),
    .funct3_i  (bus.req_funct3),
    .rdata_c_o (load_data)
  );

  // Next-state: sweep sequencing, response hand-off and same-cycle chaining.
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_clr      = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_clr   = 1'b1;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end
      end
      ST_IDLE, ST_RESP: begin
        if ((state_q == ST_RESP) && bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
        if (accept) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = req_err;
          resp_rdata_d = (req_err || bus.req_write) ? 32'd0 : load_data;
          mem_we       = bus.req_write && !req_err;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_clear_d = (state_d == ST_CLEAR);
  end

  // Control and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      busy_clear_q <= CLEAR_ON_RESET;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      busy_clear_q <= busy_clear_d;
    end
  end

  // Storage array: only the sweep or an accepted legal store modifies it.
  always_ff @(posedge clock) begin
    if (mem_clr) begin
      mem_q[clr_idx_q] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[widx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign busy_clear     = busy_clear_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu against a byte-array reference model.
module tb_data_memory_lsu;

  localparam int unsigned DEPTH = 1024;

  logic clock;
  logic reset_n;
  logic busy_clear;
  int   n_checks;
  int   n_fail;

  logic [7:0] ref_bytes [4*DEPTH];

  data_memory_lsu_if #(.ADDR_WIDTH(32)) bus ();

  data_memory_lsu #(
    .DEPTH_WORDS    (DEPTH),
    .ADDR_WIDTH     (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy_clear (busy_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) ref_bytes[i] = 8'h00;
  endtask

  // Reference behaviour: byte-addressed storage, size/alignment by arithmetic.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int unsigned size;
    logic [31:0] v;
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!w && ((f3 == 3'd4) || (f3 == 3'd5)));
    size  = 1 << f3[1:0];
    err   = !legal || ((a % size) != 0) || (a >= 4*DEPTH);
    rd    = 32'd0;
    if (err) return;
    if (w) begin
      for (int i = 0; i < int'(size); i++) ref_bytes[a+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(size); i++) v = v + (32'(ref_bytes[a+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8*size));
      rd = v;
    end
  endtask

  task automatic drive(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic rand_req(output bit w, output logic [2:0] f3, output logic [31:0] a,
                          output logic [31:0] wd);
    w = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0: f3 = 3'b000;
      1: f3 = 3'b001;
      2: f3 = 3'b010;
      3: f3 = 3'b100;
      4: f3 = 3'b101;
      default: f3 = 3'($urandom_range(0, 7));
    endcase
    a = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095));
    wd = $urandom();
  endtask

  // One isolated transaction: accept, hold one cycle, consume, check idle after.
  task automatic xact(input bit w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] got, output logic got_err);
    logic [31:0] exp_rd;
    bit exp_err;
    @(negedge clock);
    drive(w, f3, a, wd);
    bus.resp_ready = 1'b0;
    #1 chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    model(w, f3, a, wd, exp_rd, exp_err);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("resp_rdata", bus.resp_rdata, exp_rd);
    chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
    got     = bus.resp_rdata;
    got_err = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    chk("resp_drop", 32'(bus.resp_valid), 32'd0);
    bus.resp_ready = 1'b0;
  endtask

  // Counts busy_clear cycles from the current negedge, bounded.
  task automatic count_sweep(input string tag);
    int cyc;
    cyc = 0;
    chk({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
    while (busy_clear && cyc < 5000) begin
      cyc++;
      @(negedge clock);
    end
    chk({tag, "_len"}, 32'(cyc), 32'(DEPTH));
    chk({tag, "_ready_high"}, 32'(bus.req_ready), 32'd1);
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, e1, e2;
    logic        gerr;
    bit          ee1, ee2, w;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic [31:0] q_rd [$];
    bit          q_err [$];

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr  = '0;   bus.req_wdata = '0;   bus.resp_ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_busy", 32'(busy_clear), 32'd1);
    reset_n = 1'b1;
    count_sweep("sweep0");

    xact(1'b0, 3'b010, 32'h10, 32'd0, got, gerr);
    chk("lw_after_clear", got, 32'd0);

    xact(1'b1, 3'b010, 32'h20, 32'h8000_00FF, got, gerr);
    xact(1'b0, 3'b000, 32'h20, 32'd0, got, gerr); chk("lb_k", got, 32'hFFFF_FFFF);
    xact(1'b0, 3'b100, 32'h20, 32'd0, got, gerr); chk("lbu_k", got, 32'h0000_00FF);
    xact(1'b0, 3'b001, 32'h20, 32'd0, got, gerr); chk("lh_k", got, 32'h0000_00FF);
    xact(1'b0, 3'b101, 32'h20, 32'd0, got, gerr); chk("lhu_k", got, 32'h0000_00FF);
    xact(1'b0, 3'b010, 32'h20, 32'd0, got, gerr); chk("lw_k", got, 32'h8000_00FF);

    xact(1'b1, 3'b010, 32'h40, 32'h1122_3344, got, gerr);
    xact(1'b1, 3'b000, 32'h41, 32'h0000_00AB, got, gerr);
    xact(1'b0, 3'b010, 32'h40, 32'd0, got, gerr); chk("sb_merge_k", got, 32'h1122_AB44);

    xact(1'b0, 3'b010, 32'h22, 32'd0, got, gerr); chk("lw_mis_err", 32'(gerr), 32'd1);
    xact(1'b1, 3'b001, 32'h23, 32'hDEAD_BEEF, got, gerr); chk("sh_mis_err", 32'(gerr), 32'd1);
    xact(1'b0, 3'b010, 32'h1000, 32'd0, got, gerr); chk("lw_oor_err", 32'(gerr), 32'd1);
    xact(1'b1, 3'b010, 32'h1000, 32'hCAFE_F00D, got, gerr); chk("sw_oor_err", 32'(gerr), 32'd1);
    xact(1'b0, 3'b011, 32'h20, 32'd0, got, gerr); chk("f3_011_err", 32'(gerr), 32'd1);
    xact(1'b1, 3'b100, 32'h20, 32'h0000_0055, got, gerr); chk("sbu_err", 32'(gerr), 32'd1);
    xact(1'b0, 3'b010, 32'h20, 32'd0, got, gerr); chk("mem_kept_20", got, 32'h8000_00FF);
    xact(1'b0, 3'b010, 32'h00, 32'd0, got, gerr); chk("mem_kept_00", got, 32'd0);

    // Stalled response stays stable, then chains directly into the next one.
    @(negedge clock);
    drive(1'b0, 3'b010, 32'h40, 32'd0);
    bus.resp_ready = 1'b0;
    model(1'b0, 3'b010, 32'h40, 32'd0, e1, ee1);
    @(negedge clock);
    drive(1'b0, 3'b000, 32'h20, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_rdata", bus.resp_rdata, e1);
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
    end
    bus.resp_ready = 1'b1;
    model(1'b0, 3'b000, 32'h20, 32'd0, e2, ee2);
    #1 chk("chain_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("chain_valid", 32'(bus.resp_valid), 32'd1);
    chk("chain_rdata", bus.resp_rdata, e2);
    chk("chain_err", 32'(bus.resp_err), 32'(ee2));
    @(negedge clock);
    chk("chain_drop", 32'(bus.resp_valid), 32'd0);

    // Back-to-back random traffic, one response per cycle.
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin
        chk("b2b_valid", 32'(bus.resp_valid), 32'd1);
        chk("b2b_rdata", bus.resp_rdata, q_rd.pop_front());
        chk("b2b_err", 32'(bus.resp_err), 32'(q_err.pop_front()));
      end
      rand_req(w, f3, a, wd);
      drive(w, f3, a, wd);
      model(w, f3, a, wd, e1, ee1);
      q_rd.push_back(e1);
      q_err.push_back(ee1);
      #1 chk("b2b_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    chk("b2b_last_rdata", bus.resp_rdata, q_rd.pop_front());
    chk("b2b_last_err", 32'(bus.resp_err), 32'(q_err.pop_front()));
    @(negedge clock);
    chk("b2b_drop", 32'(bus.resp_valid), 32'd0);
    bus.resp_ready = 1'b0;

    // Isolated random transactions with idle gaps.
    for (int k = 0; k < 120; k++) begin
      rand_req(w, f3, a, wd);
      xact(w, f3, a, wd, got, gerr);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Reset mid-sweep, then reset while a response is pending.
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    count_sweep("sweep_mid");
    xact(1'b1, 3'b010, 32'h40, 32'h5A5A_A5A5, got, gerr);
    @(negedge clock);
    drive(1'b0, 3'b010, 32'h40, 32'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.resp_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata_zero", bus.resp_rdata, 32'd0);
    chk("rst_busy_again", 32'(busy_clear), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    count_sweep("sweep_resp");
    xact(1'b0, 3'b010, 32'h40, 32'd0, got, gerr);
    chk("cleared_after_rst", got, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words; SHALL be a power of two >= 4.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width of req_addr.
REQ-003 Parameter CLEAR_ON_RESET, default 1, enables post-reset zeroing sweep.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_wdata  input  32  store data, LSB-justified.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer takes response.
REQ-014 resp_rdata  output  32  load result, aligned and extended; 0 for stores/errors.
REQ-015 resp_err  output  1  misaligned, illegal funct3, or out-of-range access.
REQ-016 busy_clear  output  1  zeroing sweep in progress.

Function
REQ-017 FSM states SHALL be CLEAR, IDLE, RESP.
REQ-018 Transfer on the request side SHALL occur only when req_valid && req_ready.
REQ-019 req_ready SHALL be 1 in IDLE, resp_ready in RESP, 0 in CLEAR.
REQ-020 Accepted request SHALL move FSM to RESP; resp_valid asserted the next cycle (latency 1).
REQ-021 In RESP, resp_valid/rdata/err SHALL hold stable until resp_ready; then FSM returns to IDLE, or stays in RESP with the new response if a request is accepted the same cycle.
REQ-022 Store SHALL write only the addressed bytes (B: 1 byte at addr[1:0], H: 2 bytes at addr[1], W: 4 bytes) on the accept edge.
REQ-023 Load SHALL read the word at addr[log2(DEPTH_WORDS)+1:2] synchronously on the accept edge; B/H sign-extend, BU/HU zero-extend.
REQ-024 Error SHALL be flagged for: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111, or 1xx on a store; addr >= 4*DEPTH_WORDS.
REQ-025 An erroring request SHALL be accepted, SHALL not modify memory, and SHALL return resp_err=1, resp_rdata=0.
REQ-026 Store responses SHALL return resp_err per REQ-024 and resp_rdata=0.
REQ-027 A load following a store to the same word SHALL return the stored data (no stale read).

Reset
REQ-028 On reset_n low: FSM to CLEAR (CLEAR_ON_RESET=1) or IDLE (=0); resp_valid=0, resp_err=0, resp_rdata=0, clear counter=0.
REQ-029 CLEAR SHALL zero one word per cycle, index 0 to DEPTH_WORDS-1, then enter IDLE; busy_clear=1 throughout.
REQ-030 Reset asserted mid-sweep or mid-response SHALL restart from REQ-028; a pending response is discarded.
REQ-031 Memory array SHALL have no reset term other than the sweep.

Structure
REQ-032 Package data_memory_pkg SHALL hold funct3 encodings and the FSM state enum.
REQ-033 Sub-module load_aligner (combinational: word, addr[1:0], funct3 -> rdata) SHALL perform byte/half selection and extension.

Verification
REQ-034 Reset release, DEPTH_WORDS=1024 -> busy_clear high exactly 1024 cycles, req_ready 0 then 1; load W addr 0x10 returns 0.
REQ-035 SW 0x8000_00FF @0x20, then LB/LBU/LH/LHU/LW @0x20 -> 0xFFFF_FFFF, 0x0000_00FF, 0x0000_00FF, 0x0000_00FF, 0x8000_00FF.
REQ-036 SB 0xAB @0x41, LW @0x40 (word prev 0x11223344) -> 0x1122AB44.
REQ-037 LW @0x22, SH @0x23, LW @0x1000 (DEPTH 1024) -> resp_err=1, rdata 0, memory unchanged.
REQ-038 resp_ready held 0 for 5 cycles after response -> resp_valid/rdata stable, req_ready 0; back-to-back loads with resp_ready=1 -> one response per cycle.
REQ-039 reset_n pulsed low during RESP -> resp_valid drops immediately, sweep restarts from index 0.
